// File: rtl/dphy_lane_pkg.sv
// Shared state type and line-level constants for the D-PHY lane HS burst sequencer.
package dphy_lane_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHsRqst,
      StHsPrep,
      StHsZero,
      StHsSync,
      StHsData,
      StHsTrail,
      StHsExit
   } state_e;

   localparam logic [1:0] LP11 = 2'b11;
   localparam logic [1:0] LP01 = 2'b01;
   localparam logic [1:0] LP00 = 2'b00;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hB8;

   // {lp_p, lp_n} driven in each state
   function automatic logic [1:0] lp_of_state(input state_e s);
      case (s)
         StIdle, StHsExit: return LP11;
         StHsRqst:         return LP01;
         default:          return LP00;
      endcase
   endfunction

endpackage

// File: rtl/dphy_lane_hs_sequencer_if.sv
// Payload handshake and lane-side outputs of one D-PHY HS lane sequencer.
interface dphy_lane_hs_sequencer_if;
   logic       tx_req_i;
   logic [7:0] tx_data_i;
   logic       tx_valid_i;
   logic       tx_last_i;
   logic       tx_ready_o;
   logic       busy_o;
   logic       lp_p_o;
   logic       lp_n_o;
   logic       hs_en_o;
   logic [7:0] hs_data_o;
   logic       err_underflow_o;

   modport master (
      output tx_req_i, tx_data_i, tx_valid_i, tx_last_i,
      input  tx_ready_o, busy_o, lp_p_o, lp_n_o, hs_en_o, hs_data_o, err_underflow_o
   );

   modport slave (
      input  tx_req_i, tx_data_i, tx_valid_i, tx_last_i,
      output tx_ready_o, busy_o, lp_p_o, lp_n_o, hs_en_o, hs_data_o, err_underflow_o
   );
endinterface

// File: rtl/dphy_lane_timer.sv
// 8-bit load/decrement counter; o_done flags the final cycle of a loaded interval.
module dphy_lane_timer (
   input  logic       byte_clk_i,
   input  logic       reset_n_i,
   input  logic       i_load,
   input  logic [7:0] i_value,
   output logic       o_done
);

   logic [7:0] r_cnt;

   always_ff @(posedge byte_clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_cnt <= 8'd0;
      end else if (i_load) begin
         r_cnt <= i_value;
      end else if (r_cnt != 8'd0) begin
         r_cnt <= r_cnt - 8'd1;
      end
   end

   // Loading N makes done high on the Nth cycle after the load edge
   assign o_done = (r_cnt == 8'd1);

endmodule

// File: rtl/dphy_lane_hs_sequencer.sv
// Byte-clock sequencer for one MIPI D-PHY transmit lane: LP request, HS-zero, sync,
// payload, trail and exit, with Moore-decoded line levels and a registered HS byte.
module dphy_lane_hs_sequencer
   import dphy_lane_pkg::*;
#(
   parameter int unsigned T_LPX      = 2,
   parameter int unsigned T_HS_PREP  = 2,
   parameter int unsigned T_HS_ZERO  = 4,
   parameter int unsigned T_HS_TRAIL = 3,
   parameter int unsigned T_HS_EXIT  = 3,
   parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
   input logic                     byte_clk_i,
   input logic                     reset_n_i,
   dphy_lane_hs_sequencer_if.slave bus
);

   localparam logic [7:0] C_LPX   = T_LPX[7:0];
   localparam logic [7:0] C_PREP  = T_HS_PREP[7:0];
   localparam logic [7:0] C_ZERO  = T_HS_ZERO[7:0];
   localparam logic [7:0] C_TRAIL = T_HS_TRAIL[7:0];
   localparam logic [7:0] C_EXIT  = T_HS_EXIT[7:0];

   state_e     r_state;
   logic [7:0] r_hs_data;
   logic       r_err;
   logic       r_trail_bit;
   logic       r_trail_hold;

   logic       w_done;
   logic       w_tmr_load;
   logic [7:0] w_tmr_val;
   logic [1:0] w_lp;

   dphy_lane_timer u_timer (
      .byte_clk_i (byte_clk_i),
      .reset_n_i  (reset_n_i),
      .i_load     (w_tmr_load),
      .i_value    (w_tmr_val),
      .o_done     (w_done)
   );

   // Timer loads coincide with the FSM edges that enter each timed state
   always_comb begin
      w_tmr_load = 1'b0;
      w_tmr_val  = 8'd0;
      case (r_state)
         StIdle: if (bus.tx_req_i) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = C_LPX;
         end
         StHsRqst: if (w_done) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = C_PREP;
         end
         StHsPrep: if (w_done) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = C_ZERO;
         end
         StHsSync, StHsData: if (!bus.tx_valid_i) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = C_TRAIL;
         end
         StHsTrail: begin
            if (r_trail_hold) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = C_TRAIL;
            end else if (w_done) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = C_EXIT;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge byte_clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state      <= StIdle;
         r_hs_data    <= 8'h00;
         r_err        <= 1'b0;
         r_trail_bit  <= 1'b0;
         r_trail_hold <= 1'b0;
      end else begin
         case (r_state)
            StIdle: if (bus.tx_req_i) begin
               r_state <= StHsRqst;
               r_err   <= 1'b0;
            end
            StHsRqst: if (w_done) r_state <= StHsPrep;
            StHsPrep: if (w_done) begin
               r_state   <= StHsZero;
               r_hs_data <= 8'h00;
            end
            StHsZero: if (w_done) begin
               r_state   <= StHsSync;
               r_hs_data <= SYNC_BYTE;
            end
            StHsSync, StHsData: begin
               if (bus.tx_valid_i) begin
                  r_hs_data <= bus.tx_data_i;
                  if (bus.tx_last_i) begin
                     r_state      <= StHsTrail;
                     r_trail_bit  <= ~bus.tx_data_i[7];
                     r_trail_hold <= 1'b1;
                  end else begin
                     r_state <= StHsData;
                  end
               end else begin
                  // HS cannot stall: missing byte goes straight to trail
                  r_state      <= StHsTrail;
                  r_err        <= 1'b1;
                  r_trail_bit  <= ~r_hs_data[7];
                  r_hs_data    <= {8{~r_hs_data[7]}};
                  r_trail_hold <= 1'b0;
               end
            end
            StHsTrail: begin
               r_hs_data <= {8{r_trail_bit}};
               if (r_trail_hold) begin
                  r_trail_hold <= 1'b0;
               end else if (w_done) begin
                  r_state <= StHsExit;
               end
            end
            StHsExit: if (w_done) r_state <= StIdle;
            default:  r_state <= StIdle;
         endcase
      end
   end

   assign w_lp                = lp_of_state(r_state);
   assign bus.lp_p_o          = w_lp[1];
   assign bus.lp_n_o          = w_lp[0];
   assign bus.hs_en_o         = (r_state == StHsZero) || (r_state == StHsSync) ||
                                (r_state == StHsData) || (r_state == StHsTrail);
   assign bus.tx_ready_o      = (r_state == StHsSync) || (r_state == StHsData);
   assign bus.busy_o          = (r_state != StIdle);
   assign bus.hs_data_o       = r_hs_data;
   assign bus.err_underflow_o = r_err;

endmodule

// File: doc/dphy_lane_hs_sequencer.md
# dphy_lane_hs_sequencer

Byte-clock controller for one MIPI D-PHY transmit lane. It sequences a complete high-speed burst: LP-11 stop, LP-01 HS request, LP-00 prepare, HS-zero, sync byte, payload bytes, trail and HS exit. Its lane-state and parallel HS-byte outputs feed the lane serializer/bus driver, which transmits each byte LSB first. One instance is placed per data lane in the DSI transmit path.

## Interface
- T_LPX, 2: byte-clock cycles spent in LP-01 (range 1..255).
- T_HS_PREP, 2: cycles spent in LP-00 (range 1..255).
- T_HS_ZERO, 4: cycles of HS-0, with `hs_data_o` = 8'h00 (range 1..255).
- T_HS_TRAIL, 3: cycles of trail pattern after the last byte (range 1..255).
- T_HS_EXIT, 3: cycles of LP-11 after HS before a new request is accepted (range 1..255).
- SYNC_BYTE, 8'hB8: leader byte sent after HS-zero.

Ports:
- byte_clk_i  in  1  byte clock; the only clock.
- reset_n_i  in  1  asynchronous active-low reset.
- tx_req_i  in  1  burst request; level-sensitive; sampled only in IDLE.
- tx_data_i  in  8  payload byte.
- tx_valid_i  in  1  payload byte valid.
- tx_last_i  in  1  marks the final byte of the burst.
- tx_ready_o  out  1  byte accepted on an edge where valid & ready.
- busy_o  out  1  high whenever state != IDLE.
- lp_p_o, lp_n_o  out  1 each  LP line levels.
- hs_en_o  out  1  HS driver enable.
- hs_data_o  out  8  registered HS byte presented to the serializer.
- err_underflow_o  out  1  sticky flag; set on payload underflow; cleared when the next burst starts.

## Operation
- States: IDLE, HS_RQST, HS_PREP, HS_ZERO, HS_SYNC, HS_DATA, HS_TRAIL, HS_EXIT.
- Moore decode of LP and HS-enable per state:
  - IDLE, HS_EXIT: lp=11, hs_en=0.
  - HS_RQST: lp=01, hs_en=0.
  - HS_PREP: lp=00, hs_en=0.
  - HS_ZERO, HS_SYNC, HS_DATA, HS_TRAIL: lp=00, hs_en=1.
- IDLE -> HS_RQST when tx_req_i=1; this edge also clears err_underflow_o.
- HS_RQST, HS_PREP, HS_ZERO and HS_EXIT each last exactly their parameter count, then advance to the next state. HS_EXIT advances to IDLE.
- hs_data_o loads:
  - 8'h00 on entry to HS_ZERO.
  - SYNC_BYTE on the edge entering HS_SYNC.
- HS_SYNC lasts 1 cycle. tx_ready_o=1 in HS_SYNC and HS_DATA only; it is 0 in every other state.
- Accept (valid & ready): hs_data_o<=tx_data_i.
  - Without last: move to or stay in HS_DATA.
  - With last: go to HS_TRAIL and register trail_bit<=~tx_data_i[7].
- HS_TRAIL with normal entry:
  - First cycle shows the last byte.
  - Then hs_data_o<={8{trail_bit}} for T_HS_TRAIL cycles.
  - Total duration T_HS_TRAIL+1 cycles, then HS_EXIT.
- Underflow: tx_valid_i=0 while tx_ready_o=1 (HS lines cannot stall).
  - err_underflow_o<=1.
  - trail_bit<=~hs_data_o[7].
  - hs_data_o<={8{~hs_data_o[7]}}.
  - HS_TRAIL then lasts exactly T_HS_TRAIL cycles.
- tx_req_i outside IDLE is ignored. tx_req_i held high through HS_EXIT starts a new burst on the first IDLE cycle.
- tx_last_i is ignored unless valid & ready.

## Timing
- Reset values: state IDLE, lp_p_o=lp_n_o=1, hs_en_o=0, hs_data_o=8'h00, tx_ready_o=0, busy_o=0, err_underflow_o=0, trail_bit=0.
- Reset asserted mid-burst forces reset values immediately (asynchronously). The burst is abandoned and no trail is sent.
- Request edge = cycle 0.
  - HS_RQST occupies cycles 1..T_LPX.
  - SYNC_BYTE appears at cycle T_LPX+T_HS_PREP+T_HS_ZERO+1.
  - First payload byte appears one cycle after SYNC_BYTE.
  - Each following byte appears one cycle after its accept.
- All outputs are registered or decoded from the state register. tx_ready_o has no combinational path from any input.

## Structure
- Package dphy_lane_pkg holds:
  - state enum;
  - LP constants LP11=2'b11, LP01=2'b01, LP00=2'b00;
  - default SYNC_BYTE.
- One sub-module, dphy_lane_timer: 8-bit load/decrement counter with a done pulse. It is shared by all timed states, including HS_TRAIL.
- Target size: about 200 lines of RTL.

## Test plan
All scenarios use default parameters.
- **Reset:** assert reset_n_i=0 -> lp=11, hs_en=0, hs_data=00, ready=0, busy=0, err=0.
- **3-byte burst:** payload 11,22,83 -> lp 01 for 2 cycles, lp 00 for 2 cycles, then hs_en=1 with hs_data 00,00,00,00,B8,11,22,83,00,00,00 -> hs_en=0, lp=11 for 3 cycles -> IDLE; B8 appears at cycle 9.
- **Trail polarity:** single byte 7F with last -> hs_data 7F then FF,FF,FF; err stays 0.
- **Underflow:** byte 05 accepted, then tx_valid_i=0 -> err=1, hs_data 05 then FF,FF,FF -> HS_EXIT; next request clears err.
- **Back-to-back:** tx_req_i held high -> after 3 HS_EXIT cycles, 1 IDLE cycle, then lp=01 again.
- **Reset mid-burst:** reset_n_i=0 during HS_DATA -> lp=11, hs_en=0 immediately (asynchronous) -> after release, a new burst runs normally.
